// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked shifting,
// acknowledge check and start/packet timeouts. Lines are driven open-drain via output enables.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int PACKET_TIMEOUT = 100000,
    parameter int CNT_W          = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_INHIBIT    = 4'd1;
    localparam logic [3:0] ST_REQ        = 4'd2;
    localparam logic [3:0] ST_WAIT_FIRST = 4'd3;
    localparam logic [3:0] ST_SHIFT      = 4'd4;
    localparam logic [3:0] ST_ACK        = 4'd5;
    localparam logic [3:0] ST_WAIT_IDLE  = 4'd6;
    localparam logic [3:0] ST_DONE       = 4'd7;
    localparam logic [3:0] ST_FAIL       = 4'd8;

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PACKET_LAST  = CNT_W'(PACKET_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TIMER_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] TIMER_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMER_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // Odd parity: total ones across data and parity bit is odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    logic             clk_meta_r;
    logic             clk_sync_r;
    logic             clk_prev_r;
    logic             dat_meta_r;
    logic             dat_sync_r;
    logic             fall_s;
    logic [3:0]       state_r;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_inc_s;
    logic [9:0]       shift_r;
    logic [3:0]       bit_cnt_r;

    assign fall_s      = clk_prev_r & ~clk_sync_r;
    assign timer_inc_s = (timer_r == TIMER_MAX) ? timer_r : timer_r + TIMER_ONE;

    // Two-flop synchronizers plus one history flop for falling-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk_in;
            clk_sync_r <= clk_meta_r;
            clk_prev_r <= clk_sync_r;
            dat_meta_r <= ps2_dat_in;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Transfer sequencer; all outputs are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            timer_r     <= TIMER_ZERO;
            shift_r     <= 10'h3FF;
            bit_cnt_r   <= 4'd0;
            ps2_clk_oe  <= 1'b0;
            ps2_dat_oe  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy       <= 1'b0;
                    if (tx_start) begin
                        shift_r     <= {1'b1, odd_parity(tx_data), tx_data};
                        bit_cnt_r   <= 4'd0;
                        ack_err     <= 1'b0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        timer_r     <= TIMER_ZERO;
                        ps2_clk_oe  <= 1'b1;
                        state_r     <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (timer_r >= INHIBIT_LAST) begin
                        ps2_dat_oe <= 1'b1;
                        state_r    <= ST_REQ;
                    end else begin
                        timer_r <= timer_inc_s;
                    end
                end
                ST_REQ: begin
                    ps2_clk_oe <= 1'b0;
                    timer_r    <= TIMER_ZERO;
                    state_r    <= ST_WAIT_FIRST;
                end
                ST_WAIT_FIRST: begin
                    // Timeout is checked before the fall so it wins a same-cycle tie.
                    if (timer_r >= START_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_dat_oe  <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= ST_FAIL;
                    end else if (fall_s) begin
                        ps2_dat_oe <= ~shift_r[0];
                        shift_r    <= {1'b1, shift_r[9:1]};
                        bit_cnt_r  <= 4'd1;
                        timer_r    <= TIMER_ZERO;
                        state_r    <= ST_SHIFT;
                    end else begin
                        timer_r <= timer_inc_s;
                    end
                end
                ST_SHIFT: begin
                    if (timer_r >= PACKET_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_dat_oe  <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= ST_FAIL;
                    end else begin
                        timer_r <= timer_inc_s;
                        if (fall_s) begin
                            ps2_dat_oe <= ~shift_r[0];
                            shift_r    <= {1'b1, shift_r[9:1]};
                            bit_cnt_r  <= bit_cnt_r + 4'd1;
                            // Fall 10 has just put the stop bit on the line.
                            if (bit_cnt_r == 4'd9) begin
                                state_r <= ST_ACK;
                            end
                        end
                    end
                end
                ST_ACK: begin
                    if (timer_r >= PACKET_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_dat_oe  <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= ST_FAIL;
                    end else begin
                        timer_r <= timer_inc_s;
                        if (fall_s) begin
                            if (dat_sync_r) begin
                                ack_err <= 1'b1;
                            end
                            state_r <= ST_WAIT_IDLE;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (timer_r >= PACKET_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_dat_oe  <= 1'b0;
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state_r     <= ST_FAIL;
                    end else begin
                        timer_r <= timer_inc_s;
                        if (clk_sync_r && dat_sync_r) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                ST_FAIL: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a behavioural keyboard model clocks frames out of the
// host and the received bits/flags are compared with values derived from the byte sent.
module tb_ps2_host_tx;

    localparam int INH    = 50;
    localparam int START  = 400;
    localparam int PACKET = 2000;
    localparam int HALF   = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       clk_line;
    logic       dat_line;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int clk_oe_cnt = 0;
    int inh_cnt = 0;
    int release_cyc = 0;
    int rise_cyc = 0;
    logic clk_oe_prev = 1'b0;
    logic clk_line_prev = 1'b1;

    always #5 clock = ~clock;

    // Open-drain wired lines: host pull-down wins over the device drive.
    assign clk_line = ps2_clk_oe ? 1'b0 : dev_clk;
    assign dat_line = ps2_dat_oe ? 1'b0 : dev_dat;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_TIMEOUT (START),
        .PACKET_TIMEOUT(PACKET),
        .CNT_W         (20)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout_err(timeout_err)
    );

    // Line activity monitor, sampled away from the active edge.
    always @(negedge clock) begin
        cyc           <= cyc + 1;
        clk_oe_prev   <= ps2_clk_oe;
        clk_line_prev <= clk_line;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (ps2_clk_oe) clk_oe_cnt <= clk_oe_cnt + 1;
        if (ps2_clk_oe && !ps2_dat_oe) inh_cnt <= inh_cnt + 1;
        if (clk_oe_prev && !ps2_clk_oe) release_cyc <= cyc;
        if (!clk_line_prev && clk_line) rise_cyc <= cyc;
    end

    // Expected frame {stop, parity, data}: parity bit makes the ones count odd.
    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    task automatic do_send(input logic [7:0] d);
        @(negedge clock);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
    endtask

    // Keyboard model: waits for request-to-send, then generates n_pulses clocks,
    // reading the data line just before each rising edge. Pulse 11 carries the ack.
    task automatic device_run(input int n_pulses, input bit ack_bit,
                              output logic [9:0] got, output logic start_bit);
        int t;
        got       = 'x;
        start_bit = 1'bx;
        t = 0;
        while (ps2_clk_oe !== 1'b1 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) return;
        t = 0;
        while (ps2_clk_oe !== 1'b0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) return;
        start_bit = dat_line;
        repeat (5) @(negedge clock);
        for (int k = 1; k <= n_pulses; k++) begin
            if (k == 11) begin
                dev_dat = ack_bit;
                @(negedge clock);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            if (k <= 10) got[k-1] = dat_line;
            if (k == n_pulses && n_pulses < 11) return;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clock);
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (done_cnt != d0) seen = 1'b1;
        end
    endtask

    task automatic xfer(input logic [7:0] d, input bit ack_bit, output logic [9:0] got,
                        output logic start_bit, output bit seen, output int n_done);
        int d0;
        d0 = done_cnt;
        do_send(d);
        device_run(11, ack_bit, got, start_bit);
        wait_done(d0, 300, seen);
        repeat (4) @(negedge clock);
        n_done = done_cnt - d0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout_err} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout_err});
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_basic_ed();
        logic [9:0] got;
        logic sb;
        bit   seen;
        int   nd, oe0, inh0;
        oe0  = clk_oe_cnt;
        inh0 = inh_cnt;
        xfer(8'hED, 1'b0, got, sb, seen, nd);
        checks++;
        if (inh_cnt - inh0 != INH) begin
            errors++;
            $display("FAIL ed_inhibit_len: got %0d expected %0d", inh_cnt - inh0, INH);
        end
        checks++;
        if (clk_oe_cnt - oe0 != INH + 1) begin
            errors++;
            $display("FAIL ed_clk_oe_len: got %0d expected %0d", clk_oe_cnt - oe0, INH + 1);
        end
        checks++;
        if (sb !== 1'b0) begin
            errors++;
            $display("FAIL ed_start_bit: got %b expected 0", sb);
        end
        checks++;
        if (got !== 10'b11_1110_1101) begin
            errors++;
            $display("FAIL ed_frame: got %b expected %b", got, 10'b11_1110_1101);
        end
        checks++;
        if (!seen || nd != 1) begin
            errors++;
            $display("FAIL ed_done_once: got seen=%0d count=%0d expected 1/1", seen, nd);
        end
        checks++;
        if ({busy, ack_err, timeout_err, ps2_clk_oe, ps2_dat_oe} !== 5'b00000) begin
            errors++;
            $display("FAIL ed_final_flags: got %b expected 00000",
                     {busy, ack_err, timeout_err, ps2_clk_oe, ps2_dat_oe});
        end
    endtask

    task automatic test_parity();
        logic [9:0] got;
        logic sb;
        bit   seen;
        int   nd;
        xfer(8'h00, 1'b0, got, sb, seen, nd);
        checks++;
        if (got[9:8] !== 2'b11 || got[7:0] !== 8'h00) begin
            errors++;
            $display("FAIL parity_00: got %b expected %b", got, 10'b11_0000_0000);
        end
        xfer(8'h01, 1'b0, got, sb, seen, nd);
        checks++;
        if (got[9:8] !== 2'b10 || got[7:0] !== 8'h01) begin
            errors++;
            $display("FAIL parity_01: got %b expected %b", got, 10'b10_0000_0001);
        end
    endtask

    task automatic test_random();
        logic [9:0] got;
        logic [7:0] d;
        logic sb;
        bit   seen;
        int   nd;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            xfer(d, 1'b0, got, sb, seen, nd);
            checks++;
            if (got !== exp_frame(d) || sb !== 1'b0 || nd != 1 || ack_err !== 1'b0) begin
                errors++;
                $display("FAIL random_frame_%0h: got %b start=%b done=%0d ack_err=%b expected %b start=0 done=1 ack_err=0",
                         d, got, sb, nd, ack_err, exp_frame(d));
            end
        end
    endtask

    task automatic test_start_timeout();
        bit seen;
        int d0;
        d0 = done_cnt;
        do_send(8'hA5);
        wait_done(d0, 1000, seen);
        repeat (2) @(negedge clock);
        checks++;
        if (!seen || timeout_err !== 1'b1 || ack_err !== 1'b0) begin
            errors++;
            $display("FAIL start_timeout_flags: got seen=%0d timeout_err=%b ack_err=%b expected 1/1/0",
                     seen, timeout_err, ack_err);
        end
        checks++;
        if (done_cyc - release_cyc < START - 4 || done_cyc - release_cyc > START + 4) begin
            errors++;
            $display("FAIL start_timeout_delay: got %0d expected %0d", done_cyc - release_cyc, START);
        end
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy} !== 3'b000) begin
            errors++;
            $display("FAIL start_timeout_release: got %b expected 000", {ps2_clk_oe, ps2_dat_oe, busy});
        end
    endtask

    task automatic test_nack();
        logic [9:0] got;
        logic sb;
        bit   seen;
        int   nd;
        xfer(8'hF4, 1'b1, got, sb, seen, nd);
        checks++;
        if (ack_err !== 1'b1 || timeout_err !== 1'b0 || nd != 1) begin
            errors++;
            $display("FAIL nack_flags: got ack_err=%b timeout_err=%b done=%0d expected 1/0/1",
                     ack_err, timeout_err, nd);
        end
        checks++;
        if (done_cyc <= rise_cyc) begin
            errors++;
            $display("FAIL nack_done_after_idle: got done at %0d, clock release at %0d", done_cyc, rise_cyc);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] got;
        logic sb;
        bit   seen;
        int   nd;
        do_send(8'hED);
        device_run(5, 1'b0, got, sb);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({ps2_clk_oe, ps2_dat_oe, busy, ack_err, timeout_err} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b expected 00000",
                     {ps2_clk_oe, ps2_dat_oe, busy, ack_err, timeout_err});
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        reset   = 1'b0;
        repeat (5) @(negedge clock);
        xfer(8'hF4, 1'b0, got, sb, seen, nd);
        checks++;
        if (got !== exp_frame(8'hF4) || nd != 1 || ack_err !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_resend: got %b done=%0d expected %b done=1", got, nd, exp_frame(8'hF4));
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] got;
        logic sb;
        bit   seen;
        int   d0;
        d0 = done_cnt;
        do_send(8'hED);
        repeat (5) @(negedge clock);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_busy: got %b expected 1", busy);
        end
        device_run(11, 1'b1, got, sb);
        wait_done(d0, 300, seen);
        repeat (4) @(negedge clock);
        checks++;
        if (got !== exp_frame(8'hED) || ack_err !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ignored: got %b ack_err=%b expected %b ack_err=1", got, ack_err, exp_frame(8'hED));
        end
        d0 = done_cnt;
        do_send(8'hFF);
        checks++;
        if (ack_err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_clear: got ack_err=%b busy=%b expected 0/1", ack_err, busy);
        end
        device_run(11, 1'b0, got, sb);
        wait_done(d0, 300, seen);
        repeat (4) @(negedge clock);
        checks++;
        if (got !== exp_frame(8'hFF) || !seen || ack_err !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got %b seen=%0d expected %b seen=1", got, seen, exp_frame(8'hFF));
        end
    endtask

    initial begin
        test_reset();
        test_basic_ed();
        test_parity();
        test_random();
        test_start_timeout();
        test_nack();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
